// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// Optional round-robin mode is selected with the DM_ARB_RR_EN macro.
package dm_arb_pkg;

  localparam int DM_ADDR_W = 12;
  localparam int DM_DATA_W = 32;
  localparam int DM_BE_W   = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  // Byte-lane write strobes: reads never strobe a lane regardless of be.
  function automatic logic [DM_BE_W-1:0] lane_we(input logic we, input logic [DM_BE_W-1:0] be);
    return {DM_BE_W{we}} & be;
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational grant selection: requests plus arbitration state -> owner.
// DM_ARB_RR_EN selects round-robin on contention, otherwise A priority with starvation escape.
module dm_arb_pick
  import dm_arb_pkg::*;
(
  input  logic       a_req,
  input  logic       b_req,
`ifdef DM_ARB_RR_EN
  input  logic       rr_last_b,
`else
  input  logic       starved,
`endif
  output logic [1:0] owner
);

  owner_e owner_next;

  always_comb begin
    owner_next = OWN_NONE;
    if (a_req && b_req) begin
`ifdef DM_ARB_RR_EN
      owner_next = rr_last_b ? OWN_A : OWN_B;
`else
      owner_next = starved ? OWN_B : OWN_A;
`endif
    end else if (a_req) begin
      owner_next = OWN_A;
    end else if (b_req) begin
      owner_next = OWN_B;
    end
  end

  assign owner = owner_next;

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of a single-port data RAM with 1-cycle synchronous read.
// Define DM_ARB_RR_EN for round-robin contention handling instead of A priority.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        a_req,
  input  logic        a_we,
  input  logic [3:0]  a_be,
  input  logic [11:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,

  input  logic        b_req,
  input  logic        b_we,
  input  logic [3:0]  b_be,
  input  logic [11:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,

  output logic [31:0] rdata,

  output logic        dm_en,
  output logic [3:0]  dm_we,
  output logic [11:0] dm_addr,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout,

  output logic [7:0]  starve_cnt
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [1:0] owner_bits;
  owner_e     owner;
  logic       a_sel;
  logic       b_sel;
  logic       a_rvalid_reg;
  logic       b_rvalid_reg;

`ifdef DM_ARB_RR_EN
  logic rr_last_b_reg;

  dm_arb_pick u_pick (
    .a_req     (a_req),
    .b_req     (b_req),
    .rr_last_b (rr_last_b_reg),
    .owner     (owner_bits)
  );

  // Remembers who won last; resets to B so A wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_b_reg <= 1'b1;
    end else if (a_sel) begin
      rr_last_b_reg <= 1'b0;
    end else if (b_sel) begin
      rr_last_b_reg <= 1'b1;
    end
  end

  assign starve_cnt = 8'd0;
`else
  logic [7:0] starve_cnt_reg;
  logic [7:0] starve_cnt_next;
  logic       starved;

  assign starved = (starve_cnt_reg == LIMIT);

  dm_arb_pick u_pick (
    .a_req   (a_req),
    .b_req   (b_req),
    .starved (starved),
    .owner   (owner_bits)
  );

  // Counts consecutive denied B cycles, saturating; any B grant or idle B clears it.
  always_comb begin
    starve_cnt_next = 8'd0;
    if (b_req && !b_sel) begin
      starve_cnt_next = starved ? LIMIT : starve_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= 8'd0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  assign starve_cnt = starve_cnt_reg;
`endif

  assign owner = owner_e'(owner_bits);

  // Grants are forced low while reset is held, even with requests pending.
  assign a_sel = rst_n && (owner == OWN_A);
  assign b_sel = rst_n && (owner == OWN_B);

  assign a_gnt   = a_sel;
  assign b_gnt   = b_sel;
  assign dm_en   = a_sel || b_sel;
  assign dm_we   = a_sel ? lane_we(a_we, a_be) :
                   b_sel ? lane_we(b_we, b_be) : 4'b0000;
  assign dm_addr = b_sel ? b_addr  : a_addr;
  assign dm_din  = b_sel ? b_wdata : a_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_reg <= 1'b0;
      b_rvalid_reg <= 1'b0;
    end else begin
      a_rvalid_reg <= a_sel && !a_we;
      b_rvalid_reg <= b_sel && !b_we;
    end
  end

  assign a_rvalid = a_rvalid_reg;
  assign b_rvalid = b_rvalid_reg;
  assign rdata    = dm_dout;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural byte-lane RAM.
// Contention checks follow DM_ARB_RR_EN when it is defined.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [3:0]  a_be, b_be;
  logic [11:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] rdata;
  logic        dm_en;
  logic [3:0]  dm_we;
  logic [11:0] dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;
  logic [7:0]  starve_cnt;
  logic        preload;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_req      (a_req),
    .a_we       (a_we),
    .a_be       (a_be),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_gnt      (a_gnt),
    .a_rvalid   (a_rvalid),
    .b_req      (b_req),
    .b_we       (b_we),
    .b_be       (b_be),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_gnt      (b_gnt),
    .b_rvalid   (b_rvalid),
    .rdata      (rdata),
    .dm_en      (dm_en),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_din     (dm_din),
    .dm_dout    (dm_dout),
    .starve_cnt (starve_cnt)
  );

  // Read-first synchronous RAM; preload seeds the two words the directed tests use.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (preload) begin
      mem[12'h010] <= 32'hDEADBEEF;
      mem[12'h020] <= 32'hAAAAAAAA;
    end else if (dm_en) begin
      for (int k = 0; k < 4; k++) begin
        if (dm_we[k]) mem[dm_addr][8*k +: 8] <= dm_din[8*k +: 8];
      end
      dm_dout <= mem[dm_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    logic exp_b;

    rst_n = 1'b0; preload = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_be = 4'hF; a_addr = 12'h010; a_wdata = '0;
    b_req = 1'b1; b_we = 1'b0; b_be = 4'hF; b_addr = 12'h020; b_wdata = '0;

    // Reset held with both requesting: nothing may be granted.
    @(posedge clk); #1 preload = 1'b0;
    chk("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
    chk("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
    chk("rst_dm_en", {31'd0, dm_en}, 32'd0);
    chk("rst_dm_we", {28'd0, dm_we}, 32'd0);
    chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    chk("rst_starve", {24'd0, starve_cnt}, 32'd0);

    // A reads 0x010 on the first edge after reset release.
    @(negedge clk); rst_n = 1'b1; b_req = 1'b0;
    #1;
    chk("rd_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("rd_b_gnt", {31'd0, b_gnt}, 32'd0);
    chk("rd_dm_en", {31'd0, dm_en}, 32'd1);
    chk("rd_dm_addr", {20'd0, dm_addr}, 32'h010);
    chk("rd_dm_we", {28'd0, dm_we}, 32'd0);
    @(posedge clk); #1;
    chk("rd_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("rd_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    chk("rd_rdata", rdata, 32'hDEADBEEF);

    // B partial write to 0x020, then A reads the merged word.
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_be = 4'b0011; b_addr = 12'h020; b_wdata = 32'h12345678;
    #1;
    chk("wr_b_gnt", {31'd0, b_gnt}, 32'd1);
    chk("wr_dm_we", {28'd0, dm_we}, 32'h3);
    chk("wr_dm_din", dm_din, 32'h12345678);
    @(posedge clk); #1;
    chk("wr_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    chk("wr_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    @(negedge clk);
    b_req = 1'b0; b_we = 1'b0; b_be = 4'hF;
    a_req = 1'b1; a_we = 1'b0; a_be = 4'b0000; a_addr = 12'h020;
    @(posedge clk); #1;
    chk("raw_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("raw_rdata", rdata, 32'hAAAA5678);

    // Idle for 10 cycles.
    @(negedge clk); a_req = 1'b0; a_be = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_dm_en", {31'd0, dm_en}, 32'd0);
      chk("idle_dm_we", {28'd0, dm_we}, 32'd0);
      chk("idle_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    end

    // Reset asserted in the cycle after a granted A read drops the rvalid.
    @(negedge clk);
    a_req = 1'b1; a_addr = 12'h010; b_req = 1'b1; b_addr = 12'h020;
    #1 chk("prst_a_gnt", {31'd0, a_gnt}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("prst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("prst_starve", {24'd0, starve_cnt}, 32'd0);
    chk("prst_a_gnt_rst", {31'd0, a_gnt}, 32'd0);
    chk("prst_dm_en", {31'd0, dm_en}, 32'd0);
    @(posedge clk); #1;
    chk("prst_a_rvalid2", {31'd0, a_rvalid}, 32'd0);

    // Continuous contention straight out of reset.
    @(negedge clk); rst_n = 1'b1;
`ifdef DM_ARB_RR_EN
    for (int i = 0; i < 6; i++) begin
      exp_b = (i % 2) == 1;
      #1;
      chk("rr_a_gnt", {31'd0, a_gnt}, {31'd0, !exp_b});
      chk("rr_b_gnt", {31'd0, b_gnt}, {31'd0, exp_b});
      chk("rr_starve", {24'd0, starve_cnt}, 32'd0);
      @(posedge clk); #1;
      chk("rr_rvalid", {30'd0, a_rvalid, b_rvalid}, exp_b ? 32'd1 : 32'd2);
      chk("rr_rdata", rdata, exp_b ? 32'hAAAA5678 : 32'hDEADBEEF);
      @(negedge clk);
    end
`else
    for (int i = 0; i < 18; i++) begin
      exp_b = (i % 9) == 8;
      #1;
      chk("st_starve", {24'd0, starve_cnt}, i % 9);
      chk("st_a_gnt", {31'd0, a_gnt}, {31'd0, !exp_b});
      chk("st_b_gnt", {31'd0, b_gnt}, {31'd0, exp_b});
      @(posedge clk); #1;
      chk("st_rvalid", {30'd0, a_rvalid, b_rvalid}, exp_b ? 32'd1 : 32'd2);
      chk("st_rdata", rdata, exp_b ? 32'hAAAA5678 : 32'hDEADBEEF);
      @(negedge clk);
    end
`endif
    a_req = 1'b0; b_req = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive denied cycles of port B before B is forced a grant (1..255).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port a_req / a_we  input  1 / 1  CPU access request / write.
REQ-005 SHALL have port a_be  input  4  CPU byte enables.
REQ-006 SHALL have port a_addr / a_wdata  input  12 / 32  CPU word address / write data (pre-shifted lanes).
REQ-007 SHALL have port a_gnt / a_rvalid  output  1 / 1  CPU grant / read data valid.
REQ-008 SHALL have ports b_req, b_we, b_be, b_addr, b_wdata, b_gnt, b_rvalid, identical widths, for the secondary requester (loader/debug).
REQ-009 SHALL have port rdata  output  32  read data, valid only with a_rvalid or b_rvalid.
REQ-010 SHALL have ports dm_en  output  1, dm_we  output  4, dm_addr  output  12, dm_din  output  32, dm_dout  input  32 to the data RAM (1-cycle synchronous read).
REQ-011 SHALL have port starve_cnt  output  8  current B starvation count (debug).

Function
REQ-012 SHALL grant at most one port per cycle; a_gnt/b_gnt are combinational from requests and registered state.
REQ-013 SHALL grant A when only A requests, B when only B requests, none when neither.
REQ-014 SHALL, with both requesting, grant A unless starve_cnt == STARVE_LIMIT, then grant B.
REQ-015 SHALL drive dm_en=1, dm_addr/dm_din from winner, dm_we = {4{winner_we}} & winner_be; dm_en=0, dm_we=0 when no grant.
REQ-016 SHALL increment starve_cnt each cycle b_req=1 and b_gnt=0, saturating at STARVE_LIMIT.
REQ-017 SHALL clear starve_cnt on any cycle b_gnt=1 or b_req=0.
REQ-018 SHALL assert a_rvalid (b_rvalid) exactly one cycle after a granted read (we=0) of that port; rdata = dm_dout that cycle.
REQ-019 SHALL never assert a_rvalid and b_rvalid together; granted writes produce no rvalid.
REQ-020 SHALL sustain one grant per cycle back-to-back, including alternating ports; read-after-write to same word across ports follows grant order.
REQ-021 SHALL ignore a_be/b_be for reads (full word returned).
REQ-022 SHALL treat a request held across cycles as new requests each cycle; requester deasserts after gnt.

Reset
REQ-023 SHALL on rst_n=0, asynchronously clear a_rvalid, b_rvalid, starve_cnt, rr_last; gnts, dm_en, dm_we read 0 while reset held.
REQ-024 SHALL drop a pending rvalid if reset asserts in the cycle after a granted read.
REQ-025 SHALL accept requests on the first clock edge after rst_n deasserts.

Configuration
REQ-026 SHALL with DM_ARB_RR_EN defined, replace REQ-014 by round-robin: on contention grant the port not granted most recently (rr_last, reset value = B so A wins first); starve_cnt held 0.
REQ-027 SHALL without DM_ARB_RR_EN, use fixed A priority with starvation escape (REQ-014..017) and no rr_last register.

Structure
REQ-028 SHALL place owner enum (OWN_NONE, OWN_A, OWN_B) and DM_ADDR_W=12 in shared package dm_arb_pkg.
REQ-029 SHALL implement grant selection in sub-module dm_arb_pick (combinational: reqs, starve flag, rr_last -> owner); counters and rvalid pipeline stay in dm_arbiter.

Verification
REQ-030 SHALL cover: A reads addr 0x010 (RAM holds 0xDEADBEEF) -> a_gnt same cycle, a_rvalid next cycle, rdata=0xDEADBEEF, b_rvalid=0.
REQ-031 SHALL cover: A and B request continuously, STARVE_LIMIT=8 -> 8 A grants, 9th cycle b_gnt=1, starve_cnt returns 0, pattern repeats.
REQ-032 SHALL cover: B writes 0x12345678 be=4'b0011 to 0x020, then A reads 0x020 (old 0xAAAAAAAA) -> rdata=0xAAAA5678.
REQ-033 SHALL cover: rst_n low in cycle after granted A read -> a_rvalid stays 0, starve_cnt=0.
REQ-034 SHALL cover: DM_ARB_RR_EN, both request 6 cycles -> grants A,B,A,B,A,B.
REQ-035 SHALL cover: no requests -> dm_en=0, dm_we=0, both rvalid 0 for 10 cycles.
